// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage F|D|E|M|W pipeline.
// Arbitrates MEM wait, taken branch, load-use and jump hazards; keeps timeout and perf counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WriteReg,
   input  logic             EX_BranchTaken,
   input  logic             MEM_Access,
   input  logic             MEM_Ready,
   output logic             PC_Write,
   output logic             Stall_FD,
   output logic             Stall_DE,
   output logic             Stall_EM,
   output logic             Flush_FD,
   output logic             Flush_DE,
   output logic             Flush_EM,
   output logic             Flush_MW,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   localparam logic [7:0]       TmoLast = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [7:0]       wcnt_q, wcnt_d;
   logic             mem_err_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             tmo, memhold, loaduse, flush_evt;

   always_comb begin
      tmo     = (state_q == StMemWait) && (wcnt_q == TmoLast);
      memhold = MEM_Access & ~MEM_Ready & ~tmo;
      loaduse = EX_MemRead && (EX_WriteReg != 5'd0) &&
                ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                 (ID_UsesRt && (ID_Rt == EX_WriteReg)));

      PC_Write  = 1'b1;
      Stall_FD  = 1'b0;
      Stall_DE  = 1'b0;
      Stall_EM  = 1'b0;
      Flush_FD  = 1'b0;
      Flush_DE  = 1'b0;
      Flush_EM  = 1'b0;
      Flush_MW  = 1'b0;
      flush_evt = 1'b0;
      state_d   = StRun;
      wcnt_d    = 8'd0;

      if (!reset) begin
         PC_Write = 1'b0;
         Flush_FD = 1'b1;
         Flush_DE = 1'b1;
         Flush_EM = 1'b1;
         Flush_MW = 1'b1;
      end else if (memhold) begin
         // Whole front end freezes; MEM/WB gets bubbles until the access completes.
         PC_Write = 1'b0;
         Stall_FD = 1'b1;
         Stall_DE = 1'b1;
         Stall_EM = 1'b1;
         Flush_MW = 1'b1;
         state_d  = StMemWait;
         wcnt_d   = (state_q == StRun) ? 8'd1 : wcnt_q + 8'd1;
      end else if (EX_BranchTaken) begin
         Flush_FD  = 1'b1;
         Flush_DE  = 1'b1;
         flush_evt = 1'b1;
      end else if (loaduse) begin
         // A coincident jump stays in ID and is taken once the load-use clears.
         PC_Write = 1'b0;
         Stall_FD = 1'b1;
         Flush_DE = 1'b1;
      end else if (ID_Jump) begin
         Flush_FD  = 1'b1;
         flush_evt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StRun;
         wcnt_q      <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (tmo) mem_err_q <= 1'b1;
         if (!PC_Write) stall_cnt_q <= stall_cnt_q + CntOne;
         if (flush_evt) flush_cnt_q <= flush_cnt_q + CntOne;
      end
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance at default timeout, one with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

   // Control vector order: {PC_Write, Stall_FD, Stall_DE, Stall_EM, Flush_FD, Flush_DE, Flush_EM, Flush_MW}
   localparam logic [7:0] CtlRst  = 8'b0000_1111;
   localparam logic [7:0] CtlNorm = 8'b1000_0000;
   localparam logic [7:0] CtlLdu  = 8'b0100_0100;
   localparam logic [7:0] CtlBr   = 8'b1000_1100;
   localparam logic [7:0] CtlJmp  = 8'b1000_1000;
   localparam logic [7:0] CtlHold = 8'b0111_0001;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_wreg;
   logic        id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_br, mem_access, mem_ready;

   logic        pcw_a, sfd_a, sde_a, sem_a, ffd_a, fde_a, fem_a, fmw_a, err_a;
   logic [31:0] scnt_a, fcnt_a;
   logic        pcw_b, sfd_b, sde_b, sem_b, ffd_b, fde_b, fem_b, fmw_b, err_b;
   logic [31:0] scnt_b, fcnt_b;
   logic [7:0]  ctl_a, ctl_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign ctl_a = {pcw_a, sfd_a, sde_a, sem_a, ffd_a, fde_a, fem_a, fmw_a};
   assign ctl_b = {pcw_b, sfd_b, sde_b, sem_b, ffd_b, fde_b, fem_b, fmw_b};

   pipe_hazard_ctrl dut_a (
      .clk(clk), .reset(reset), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_uses_rs),
      .ID_UsesRt(id_uses_rt), .ID_Jump(id_jump), .EX_MemRead(ex_memread), .EX_WriteReg(ex_wreg),
      .EX_BranchTaken(ex_br), .MEM_Access(mem_access), .MEM_Ready(mem_ready),
      .PC_Write(pcw_a), .Stall_FD(sfd_a), .Stall_DE(sde_a), .Stall_EM(sem_a),
      .Flush_FD(ffd_a), .Flush_DE(fde_a), .Flush_EM(fem_a), .Flush_MW(fmw_a),
      .mem_err(err_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_uses_rs),
      .ID_UsesRt(id_uses_rt), .ID_Jump(id_jump), .EX_MemRead(ex_memread), .EX_WriteReg(ex_wreg),
      .EX_BranchTaken(ex_br), .MEM_Access(mem_access), .MEM_Ready(mem_ready),
      .PC_Write(pcw_b), .Stall_FD(sfd_b), .Stall_DE(sde_b), .Stall_EM(sem_b),
      .Flush_FD(ffd_b), .Flush_DE(fde_b), .Flush_EM(fem_b), .Flush_MW(fmw_b),
      .mem_err(err_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs change at posedge+1; combinational outputs are checked after a further #1.
   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_wreg = '0;
      id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; ex_memread = 0; ex_br = 0;
      mem_access = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      settle();
      check("rst_ctl", 32'(ctl_a), 32'(CtlRst));
      step();
      step();
      reset = 1'b1;
      settle();
      check("rst_scnt", scnt_a, 0);
      check("rst_fcnt", fcnt_a, 0);
      check("rst_err", 32'(err_a), 0);
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      step();
      do_reset();

      // Load-use on rs, then clears
      check("idle_ctl", 32'(ctl_a), 32'(CtlNorm));
      ex_memread = 1; ex_wreg = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
      settle();
      check("ldu_rs_ctl", 32'(ctl_a), 32'(CtlLdu));
      step();
      ex_memread = 0;
      settle();
      check("ldu_after_ctl", 32'(ctl_a), 32'(CtlNorm));
      step();
      check("ldu_scnt", scnt_a, 1);
      check("ldu_fcnt", fcnt_a, 0);

      // rt match only counts when UsesRt
      ex_memread = 1; ex_wreg = 5'd9; id_rs = 5'd1; id_uses_rs = 1; id_rt = 5'd9; id_uses_rt = 0;
      settle();
      check("rt_unused_ctl", 32'(ctl_a), 32'(CtlNorm));
      id_uses_rt = 1;
      settle();
      check("ldu_rt_ctl", 32'(ctl_a), 32'(CtlLdu));
      step();

      // $0 never stalls
      ex_wreg = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      settle();
      check("r0_ctl", 32'(ctl_a), 32'(CtlNorm));
      step();
      check("r0_scnt", scnt_a, 2);

      // Branch beats load-use
      ex_wreg = 5'd8; id_rs = 5'd8; ex_br = 1;
      settle();
      check("br_ldu_ctl", 32'(ctl_a), 32'(CtlBr));
      step();
      check("br_fcnt", fcnt_a, 1);
      check("br_scnt", scnt_a, 2);

      // Memory wait: 3 stall cycles then ready
      do_reset();
      mem_access = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("memw_hold%0d", i), 32'(ctl_a), 32'(CtlHold));
         step();
      end
      mem_ready = 1;
      settle();
      check("memw_release", 32'(ctl_a), 32'(CtlNorm));
      step();
      mem_access = 0; mem_ready = 0;
      settle();
      check("memw_after", 32'(ctl_a), 32'(CtlNorm));
      check("memw_scnt", scnt_a, 3);
      step();
      // Back in RUN: ready alongside access costs nothing
      mem_access = 1; mem_ready = 1;
      settle();
      check("memw_zero", 32'(ctl_a), 32'(CtlNorm));
      step();
      check("memw_zero_scnt", scnt_a, 3);
      check("memw_err", 32'(err_a), 0);
      mem_access = 0; mem_ready = 0;

      // Branch held off by memhold; jump deferred by load-use
      do_reset();
      mem_access = 1; ex_br = 1;
      for (int i = 0; i < 2; i++) begin
         settle();
         check($sformatf("brhold%0d", i), 32'(ctl_a), 32'(CtlHold));
         step();
      end
      check("brhold_fcnt", fcnt_a, 0);
      mem_ready = 1;
      settle();
      check("brhold_release", 32'(ctl_a), 32'(CtlBr));
      step();
      check("brhold_fcnt2", fcnt_a, 1);
      mem_access = 0; mem_ready = 0; ex_br = 0;
      ex_memread = 1; ex_wreg = 5'd5; id_rt = 5'd5; id_uses_rt = 1; id_jump = 1;
      settle();
      check("jmp_ldu_ctl", 32'(ctl_a), 32'(CtlLdu));
      step();
      ex_memread = 0;
      settle();
      check("jmp_ctl", 32'(ctl_a), 32'(CtlJmp));
      step();
      check("jmp_fcnt", fcnt_a, 2);
      check("jmp_scnt", scnt_a, 3);
      id_jump = 0; id_uses_rt = 0;

      // Timeout on the MEM_TIMEOUT=4 instance, fresh wait, then reset mid-wait
      do_reset();
      mem_access = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("tmo_hold%0d", i), 32'(ctl_b), 32'(CtlHold));
         check($sformatf("tmo_err_pre%0d", i), 32'(err_b), 0);
         step();
      end
      settle();
      check("tmo_release", 32'(ctl_b), 32'(CtlNorm));
      check("tmo_err_same", 32'(err_b), 0);
      step();
      check("tmo_err_set", 32'(err_b), 1);
      check("tmo_scnt", scnt_b, 3);
      check("tmo_fresh", 32'(ctl_b), 32'(CtlHold));
      step();
      check("tmo_fresh2", 32'(ctl_b), 32'(CtlHold));
      step();
      check("tmo_err_sticky", 32'(err_b), 1);
      reset = 0;
      settle();
      check("rstw_ctl_b", 32'(ctl_b), 32'(CtlRst));
      check("rstw_ctl_a", 32'(ctl_a), 32'(CtlRst));
      step();
      reset = 1; mem_access = 0;
      settle();
      check("rstw_run_b", 32'(ctl_b), 32'(CtlNorm));
      check("rstw_err_b", 32'(err_b), 0);
      check("rstw_scnt_b", scnt_b, 0);
      check("rstw_fcnt_b", fcnt_b, 0);
      check("rstw_scnt_a", scnt_a, 0);
      // Fresh access after reset starts from RUN
      mem_access = 1;
      settle();
      check("rstw_new_hold", 32'(ctl_b), 32'(CtlHold));
      step();
      mem_access = 0;
      step();
      check("rstw_new_scnt", scnt_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage F|D|E|M|W pipeline.
- Each cycle it decides which pipeline registers hold, which are flushed to bubbles, and whether the PC advances.
- Inputs it arbitrates between: load-use hazards, taken branches (resolved in EX), jumps (resolved in ID) and multi-cycle data-memory/MMIO accesses in MEM.
- Also keeps a bounded memory-wait timeout and performance counters.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for MEM_Ready before the access is abandoned (legal range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low (asserted when 0).
- ID_Rs  in  5  source register rs of the instruction in ID.
- ID_Rt  in  5  source register rt of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- ID_Jump  in  1  ID instruction is j/jal/jr/jalr.
- EX_MemRead  in  1  EX instruction is a load.
- EX_WriteReg  in  5  destination register of the EX instruction.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- MEM_Access  in  1  MEM stage holds a load/store needing the handshake.
- MEM_Ready  in  1  memory completes the MEM access this cycle.
- PC_Write  out  1  PC register load enable.
- Stall_FD  out  1  hold IF/ID register.
- Stall_DE  out  1  hold ID/EX register.
- Stall_EM  out  1  hold EX/MEM register.
- Flush_FD  out  1  load bubble into IF/ID.
- Flush_DE  out  1  load bubble into ID/EX.
- Flush_EM  out  1  load bubble into EX/MEM.
- Flush_MW  out  1  load bubble into MEM/WB.
- mem_err  out  1  sticky: a MEM access timed out.
- stall_cnt  out  CNT_W  cycles with PC_Write=0 outside reset.
- flush_cnt  out  CNT_W  cycles with Flush_FD=1 due to branch or jump.

Behaviour:
- FSM states: RUN, MEM_WAIT. Wait counter wcnt is 8 bits.
- Control outputs are combinational from the current state, wcnt and the inputs. No added latency.
- State, wcnt, mem_err and the counters are registered.
- While reset==0:
  - PC_Write=0, all Stall_*=0, all Flush_*=1.
  - Next state is RUN; wcnt, mem_err, stall_cnt and flush_cnt are cleared.
  - Reset mid-wait abandons the access with no error.
- Hazard terms:
  - memhold = MEM_Access & !MEM_Ready & !tmo.
  - tmo = (state==MEM_WAIT) & (wcnt==MEM_TIMEOUT-1).
  - loaduse = EX_MemRead & EX_WriteReg!=0 & ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
- Priority, highest first. Exactly one case applies per cycle:
  1. memhold: PC_Write=0, Stall_FD=Stall_DE=Stall_EM=1, Flush_MW=1. Branch, jump and load-use are all ignored this cycle.
  2. EX_BranchTaken: PC_Write=1 (target), Flush_FD=1, Flush_DE=1. Load-use and jump are ignored, because the ID instruction is squashed.
  3. loaduse: PC_Write=0, Stall_FD=1, Flush_DE=1. A coincident ID_Jump is deferred and re-evaluated next cycle.
  4. ID_Jump: PC_Write=1, Flush_FD=1.
  5. Otherwise PC_Write=1 and all stalls/flushes are 0.
- Transitions:
  - RUN -> MEM_WAIT when memhold; wcnt<=1.
  - MEM_WAIT stays while memhold; wcnt increments.
  - MEM_WAIT -> RUN when MEM_Ready=1 or tmo=1; wcnt<=0.
  - MEM_Ready in the same cycle as MEM_Access costs zero stall cycles and stays in RUN.
- Timeout:
  - On the tmo cycle the stall releases even without MEM_Ready and mem_err<=1.
  - mem_err stays set until reset.
  - The pipeline advances, so a new MEM_Access next cycle starts a fresh wait.
- Counters:
  - stall_cnt increments every cycle PC_Write=0 with reset==1.
  - flush_cnt increments on cases 2 and 4.
  - Both wrap modulo 2^CNT_W.
- Register $0 never causes a load-use stall.

Test Plan:
- lw $8 in EX (EX_MemRead=1, EX_WriteReg=8), ID_Rs=8, ID_UsesRs=1 -> one cycle with PC_Write=0, Stall_FD=1, Flush_DE=1. Next cycle with EX_MemRead=0 -> PC_Write=1. stall_cnt=1.
- Same as above but EX_WriteReg=0 -> no stall. Separately, EX_BranchTaken=1 together with the load-use -> Flush_FD=Flush_DE=1, PC_Write=1, flush_cnt increments.
- MEM_Access=1, MEM_Ready held 0 for 3 cycles then 1 -> Stall_FD/DE/EM=1 and Flush_MW=1 for exactly 3 cycles, 4th cycle normal. State returns to RUN, stall_cnt=3.
- MEM_TIMEOUT=4, MEM_Access=1, MEM_Ready never asserted -> stall for 3 cycles, release on the 4th with mem_err=1 from the following cycle. mem_err stays 1 until reset=0.
- EX_BranchTaken=1 during memhold -> no flush until the stall releases. ID_Jump with load-use -> stall first, then Flush_FD=1 on the next cycle.
- Assert reset=0 in MEM_WAIT after 2 wait cycles -> next edge gives state RUN, counters 0, mem_err=0. While reset=0: all Flush_*=1, PC_Write=0.
